// File: rtl/sap1_ctrl.sv
// sap1_ctrl: SAP-1 controller-sequencer, one-hot T1..T6 ring plus opcode decode into the control word.
// Define SAP1_CTRL_STEP_EN to add a single-step input that gates ring advance and load strobes.
module sap1_ctrl #(
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                clr_n,
`ifdef SAP1_CTRL_STEP_EN
    input  logic                step,
`endif
    input  logic [3:0]          opcode,
    output logic [T_STATES-1:0] t_state,
    output logic                cp,
    output logic                ep,
    output logic                lm,
    output logic                ce,
    output logic                li,
    output logic                ei,
    output logic                la,
    output logic                ea,
    output logic                su,
    output logic                eu,
    output logic                lb,
    output logic                lo,
    output logic                hlt
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    ring_t ring, ring_nx;
    logic  hlt_nx, adv, stop, en, ld, mem, alu, out;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ring <= T1;
            hlt  <= 1'b0;
        end else begin
            ring <= ring_nx;
            hlt  <= hlt_nx;
        end
    end

    always_comb begin
`ifdef SAP1_CTRL_STEP_EN
        adv = step & ~hlt;
`else
        adv = ~hlt;
`endif
        mem     = opcode == 4'b0000 || opcode == 4'b0001 || opcode == 4'b0010;
        alu     = opcode == 4'b0001 || opcode == 4'b0010;
        out     = opcode == 4'b1110;
        stop    = adv && ring == T4 && opcode == 4'b1111;
        hlt_nx  = hlt | stop;
        ring_nx = adv && !stop ? ring_t'({ring[4:0], ring[5]}) : ring;
        // bus enables survive a stall; loads only fire on an advancing edge
        en      = clr_n & ~hlt;
        ld      = en & adv;
        ep      = en & (ring == T1);
        cp      = ld & (ring == T2);
        lm      = ld & ((ring == T1) | ((ring == T4) & mem));
        ce      = en & ((ring == T3) | ((ring == T5) & mem));
        li      = ld & (ring == T3);
        ei      = en & (ring == T4) & mem;
        ea      = en & (ring == T4) & out;
        lo      = ld & (ring == T4) & out;
        lb      = ld & (ring == T5) & alu;
        la      = ld & (((ring == T5) & (opcode == 4'b0000)) | ((ring == T6) & alu));
        eu      = en & (ring == T6) & alu;
        su      = en & (ring == T6) & (opcode == 4'b0010);
    end

    assign t_state = ring;
endmodule

// File: tb/tb_sap1_ctrl.sv
// tb_sap1_ctrl: table vectors, random instruction stream against a behavioural model, and
// hand sequences for halt, mid-instruction reset and (with SAP1_CTRL_STEP_EN) single-stepping.
module tb_sap1_ctrl;
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100,
                            LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010,
                            SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] w4;
        logic [11:0] w5;
        logic [11:0] w6;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  opcode = 4'b0;
    logic [5:0]  t_state;
    logic        cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [11:0] word;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[6];
`ifdef SAP1_CTRL_STEP_EN
    logic        step = 1'b1;
`endif

    sap1_ctrl #(.T_STATES(6)) dut (
        .clk(clk), .clr_n(clr_n),
`ifdef SAP1_CTRL_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .t_state(t_state),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
        .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
    );

    assign word = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // strobes each instruction asserts in T4..T6, straight from the instruction set
    function automatic logic [11:0] model(input int t, input logic [3:0] op);
        case (op)
            4'b0000: return t == 4 ? EI | LM : t == 5 ? CE | LA : 12'h0;
            4'b0001: return t == 4 ? EI | LM : t == 5 ? CE | LB : t == 6 ? EU | LA : 12'h0;
            4'b0010: return t == 4 ? EI | LM : t == 5 ? CE | LB : t == 6 ? EU | LA | SU : 12'h0;
            4'b1110: return t == 4 ? EA | LO : 12'h0;
            default: return 12'h0;
        endcase
    endfunction

    task automatic exec(input logic [3:0] op, input int n, input logic [11:0] w4,
                        input logic [11:0] w5, input logic [11:0] w6, input string nm);
        logic [11:0] exp;
        for (int t = 1; t <= n; t++) begin
            opcode = t < 3 ? 4'($urandom) : op;
            exp = t == 1 ? EP | LM : t == 2 ? CP : t == 3 ? CE | LI : t == 4 ? w4 : t == 5 ? w5 : w6;
            @(negedge clk);
            check($sformatf("%s T%0d ring/hlt", nm, t), {25'b0, hlt, t_state}, 32'(1 << (t - 1)));
            check($sformatf("%s T%0d word", nm, t), 32'(word), 32'(exp));
            check($sformatf("%s T%0d bus", nm, t), 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic halt_seq(input int n);
        exec(4'hF, 3, 12'h0, 12'h0, 12'h0, "hlt");
        opcode = 4'hF;
        @(negedge clk);
        check("hlt T4", {13'b0, hlt, t_state, word}, {13'b0, 1'b0, 6'b001000, 12'h0});
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("halted %0d", i), {13'b0, hlt, t_state, word}, {13'b0, 1'b1, 6'b001000, 12'h0});
        end
        clr_n = 1'b0;
        #1;
        check("hlt clear", {13'b0, hlt, t_state, word}, {13'b0, 1'b0, 6'b000001, 12'h0});
        @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'b0000, EI | LM, CE | LA, 12'h0};
        vecs[1] = '{4'b0001, EI | LM, CE | LB, EU | LA};
        vecs[2] = '{4'b0010, EI | LM, CE | LB, EU | LA | SU};
        vecs[3] = '{4'b1110, EA | LO, 12'h0, 12'h0};
        vecs[4] = '{4'b0111, 12'h0, 12'h0, 12'h0};
        vecs[5] = '{4'b1010, 12'h0, 12'h0, 12'h0};

        @(negedge clk);
        check("reset", {13'b0, hlt, t_state, word}, {13'b0, 1'b0, 6'b000001, 12'h0});
        repeat (3) @(posedge clk);
        #1;
        clr_n = 1'b1;

        foreach (vecs[i]) exec(vecs[i].op, 6, vecs[i].w4, vecs[i].w5, vecs[i].w6, $sformatf("vec%0d", i));

        for (int k = 0; k < 40; k++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF) halt_seq(3);
            else exec(op, 6, model(4, op), model(5, op), model(6, op), $sformatf("rnd%0d", k));
        end

        halt_seq(20);
        exec(4'b0000, 6, EI | LM, CE | LA, 12'h0, "post-hlt");

        exec(4'b0001, 4, EI | LM, 12'h0, 12'h0, "mid");
        #2;
        clr_n = 1'b0;
        #1;
        check("mid reset", {13'b0, hlt, t_state, word}, {13'b0, 1'b0, 6'b000001, 12'h0});
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        exec(4'b0010, 6, EI | LM, CE | LB, EU | LA | SU, "after-mid");

`ifdef SAP1_CTRL_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall %0d", i), {14'b0, t_state, word}, {14'b0, 6'b000001, EP});
        end
        @(posedge clk);
        #1;
        step = 1'b1;
        @(negedge clk);
        check("step T1", {14'b0, t_state, word}, {14'b0, 6'b000001, EP | LM});
        @(posedge clk);
        #1;
        step = 1'b0;
        @(negedge clk);
        check("step T2", {14'b0, t_state, word}, {14'b0, 6'b000010, 12'h0});
        step = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sap1_ctrl.md
# sap1_ctrl

Controller-sequencer for the SAP-1 datapath. Runs the six-state ring counter (T1..T6) and decodes the 4-bit opcode from the instruction register into the control word. That word drives the program counter, MAR, RAM, IR, accumulator (`la`/`ea`), adder/subtractor, B register and output register. It is the only source of `la`/`ea` and of every other load/enable strobe on the bus.

## Interface
- `T_STATES`, 6: ring length. It is fixed at 6; other values are unsupported.
- `clk  in  1`: system clock. All datapath registers load on the rising edge.
- `clr_n  in  1`: asynchronous, active-low reset.
- `opcode  in  4`: IR upper nibble. Sampled only in T4..T6.
- `t_state  out  6`: one-hot ring. Bit 0 = T1, bit 5 = T6.
- `cp ep lm ce li ei  out  1 each`:
  - `cp`: PC count.
  - `ep`: PC to bus.
  - `lm`: MAR load.
  - `ce`: RAM to bus.
  - `li`: IR load.
  - `ei`: IR operand to bus.
- `la ea su eu lb lo  out  1 each`:
  - `la`: accumulator load.
  - `ea`: accumulator to bus.
  - `su`: subtract select.
  - `eu`: adder/subtractor to bus.
  - `lb`: B register load.
  - `lo`: output register load.
- `hlt  out  1`: halted flag.
- All control outputs are active-high.

## Operation
- State: the one-hot ring `t_state` plus the `hlt` flag.
- Each rising edge with `clr_n`=1 and `hlt`=0 rotates the ring T1→T2→…→T6→T1.
- Control word is a combinational decode of (`t_state`, `opcode`), gated to all-zero while `clr_n`=0.
- Fetch states, independent of opcode:
  - T1: `ep`, `lm`.
  - T2: `cp`.
  - T3: `ce`, `li`.
- LDA 0000:
  - T4: `ei`, `lm`.
  - T5: `ce`, `la`.
  - T6: none.
- ADD 0001:
  - T4: `ei`, `lm`.
  - T5: `ce`, `lb`.
  - T6: `eu`, `la`.
- SUB 0010: same as ADD, except T6 also asserts `su`.
- OUT 1110:
  - T4: `ea`, `lo`.
  - T5, T6: none.
- HLT 1111: in T4 no strobes are asserted. The rising edge ending T4 sets `hlt`=1 and the ring does not advance.
- While halted:
  - Ring frozen at T4, control word all-zero.
  - Exit only via `clr_n`.
- Any other opcode is a NOP: T4..T6 assert nothing.
- Bus invariant: at most one of `ep`, `ce`, `ei`, `ea`, `eu` is high in any state, for every opcode.

## Timing
- Reset state: `t_state`=000001, `hlt`=0, all control outputs 0 while `clr_n`=0.
- After `clr_n` rises, the T1 word is valid until the first rising edge, which moves the ring to T2.
- The control word for Tn is valid for the whole Tn cycle. Datapath consumes it at the rising edge that ends Tn.
- Instruction latency: 6 clocks per instruction, fixed, including NOPs.
- HLT: `hlt` rises one clock after T4 is entered (on the edge ending T4).
- Reset mid-instruction:
  - Ring returns to T1 immediately and `hlt` clears.
  - Datapath register contents are not restored.
- `opcode` changing during T1..T3 has no effect on outputs. It must be stable from the T3-ending edge through T6.

## Configuration
- `SAP1_CTRL_STEP_EN` defined: adds input `step` (1 bit, active-high, one-clock pulse from an external debouncer).
  - The ring advances only on rising edges where `step`=1.
  - While stalled, load/count strobes (`cp`, `lm`, `li`, `la`, `lb`, `lo`) are masked to 0. Bus enables (`ep`, `ce`, `ei`, `ea`, `eu`, `su`) stay asserted.
  - In the stepped edge the full word is presented, so each step executes exactly one T-state.
  - A `step` pulse while halted is ignored. `clr_n` still works asynchronously.
- Not defined: no `step` port; the ring advances every clock as described above.

## Test plan
- Reset then LDA: `clr_n` low 3 clocks then high, `opcode`=0000. Expect:
  - `t_state` 000001→000010→…→100000→000001 over 6 clocks.
  - T1 `ep`=`lm`=1, T4 `ei`=`lm`=1, T5 `ce`=`la`=1.
  - No strobes in T6.
- ADD vs SUB: `opcode`=0001, then 0010 on the next instruction. Expect:
  - T5 `ce`=`lb`=1.
  - T6 `eu`=`la`=1, with `su`=0 for ADD and `su`=1 for SUB.
- OUT and NOP:
  - `opcode`=1110: T4 `ea`=`lo`=1, T5/T6 all-zero.
  - `opcode`=0111: T4..T6 all-zero, and the ring still returns to T1 after 6 clocks.
- HLT: `opcode`=1111. Expect:
  - `hlt`=1 on the edge ending T4.
  - `t_state` held at 001000 and outputs zero for 20 further clocks.
  - `clr_n` pulse → `t_state`=000001, `hlt`=0.
- Mid-instruction reset: assert `clr_n` low asynchronously during T5 of an ADD. Expect:
  - Outputs zero within the same cycle.
  - After release, T1 word (`ep`, `lm`) appears.
- With `SAP1_CTRL_STEP_EN`: hold `step`=0 for 10 clocks, then pulse it once. Expect:
  - Ring holds at T1 with `ep`=1, `lm`=0 throughout the hold.
  - `lm`=1 only in the pulsed cycle.
  - Ring at T2 after the pulse.
